// File: rtl/prism_cfg_pkg.sv
// Shared definitions for the PRISM configuration latch loader and readback engine:
// debug register addresses, index-width helper and readback state type.
package prism_cfg_pkg;

    localparam logic [5:0] CFG_LSB = 6'h10;
    localparam logic [5:0] CFG_MSB = 6'h14;
    localparam logic [5:0] RB_REQ  = 6'h18;
    localparam logic [5:0] RB_STAT = 6'h1C;

    function automatic int unsigned idx_bits(input int unsigned depth);
        if (depth > 16)
            return 5;
        else if (depth > 8)
            return 4;
        else
            return 3;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SETTLE
    } rb_state_t;

endpackage

// File: rtl/latch_readback_if.sv
// Debug register bus shared by the configuration latch loader and readback engine.
interface latch_readback_if;

    logic        debug_wr;
    logic        debug_rd;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (
        output debug_wr,
        output debug_rd,
        output address,
        output data_in,
        input  data_out
    );

    modport slave (
        input  debug_wr,
        input  debug_rd,
        input  address,
        input  data_in,
        output data_out
    );

endinterface

// File: rtl/prism_entry_mux.sv
// Combinational DEPTH:1 selector of one WIDTH-bit entry from the flattened latch array.
module prism_entry_mux #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned IDX_BITS = 3
) (
    input  logic [DEPTH*WIDTH-1:0] latch_q,
    input  logic [IDX_BITS-1:0]    index,
    output logic [WIDTH-1:0]       entry
);

    always_comb begin
        entry = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (index == IDX_BITS'(i))
                entry = latch_q[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/latch_readback.sv
// Debug readback engine: captures one latch entry once the loader is idle and
// serves it as two 32-bit words, with optional auto-increment sweep.
module latch_readback
    import prism_cfg_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    latch_readback_if.slave        dbg,
    input  logic                   loader_busy,
    input  logic [DEPTH*WIDTH-1:0] latch_q,
    output logic                   rb_busy
);

    localparam int unsigned IDX_BITS = idx_bits(DEPTH);

    rb_state_t           state;
    logic [IDX_BITS-1:0] index;
    logic                autoinc;
    logic [WIDTH-1:0]    hold_q;
    logic                valid;
    logic                err;
    logic                ovr;

    logic [WIDTH-1:0]    entry;
    logic                req_wr;
    logic                req_oob;
    logic                inc_rd;
    logic [IDX_BITS-1:0] next_index;
    logic [31:0]         status;

    prism_entry_mux #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .IDX_BITS (IDX_BITS)
    ) u_entry_mux (
        .latch_q (latch_q),
        .index   (index),
        .entry   (entry)
    );

    // The range check covers the whole index field below the autoinc bit, so an
    // index that aliases into range after truncation is still flagged.
    assign req_wr     = dbg.debug_wr && (dbg.address == RB_REQ);
    assign req_oob    = dbg.data_in[7:0] >= 8'(DEPTH);
    assign inc_rd     = dbg.debug_rd && (dbg.address == CFG_MSB) && autoinc && valid;
    assign next_index = (index == IDX_BITS'(DEPTH - 1)) ? '0 : index + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            index   <= '0;
            autoinc <= 1'b0;
            hold_q  <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
            ovr     <= 1'b0;
            rb_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_wr) begin
                        ovr <= 1'b0;
                        if (req_oob) begin
                            err <= 1'b1;
                        end else begin
                            index   <= dbg.data_in[IDX_BITS-1:0];
                            autoinc <= dbg.data_in[8];
                            err     <= 1'b0;
                            valid   <= 1'b0;
                            rb_busy <= 1'b1;
                            state   <= ARM;
                        end
                    end else if (inc_rd) begin
                        index   <= next_index;
                        err     <= 1'b0;
                        valid   <= 1'b0;
                        rb_busy <= 1'b1;
                        state   <= ARM;
                    end
                end
                ARM: begin
                    if (req_wr)
                        ovr <= 1'b1;
                    if (!loader_busy)
                        state <= SETTLE;
                end
                SETTLE: begin
                    if (req_wr)
                        ovr <= 1'b1;
                    if (!loader_busy) begin
                        hold_q  <= entry;
                        valid   <= 1'b1;
                        rb_busy <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state <= ARM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        status               = '0;
        status[0]            = valid;
        status[1]            = rb_busy;
        status[2]            = autoinc;
        status[3]            = err;
        status[4]            = ovr;
        status[8 +: IDX_BITS] = index;
    end

    always_comb begin
        dbg.data_out = '0;
        case (dbg.address)
            CFG_LSB: dbg.data_out = hold_q[31:0];
            CFG_MSB: dbg.data_out = 32'(hold_q >> 32);
            RB_STAT: dbg.data_out = status;
            default: dbg.data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_latch_readback.sv
// Self-checking bench for latch_readback: transaction-level model compared every
// cycle, plus directed reads against hand-computed register values.
module tb_latch_readback;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic loader_busy;
    logic rb_busy;
    logic [DEPTH*WIDTH-1:0] latch_q;

    latch_readback_if dbg ();

    latch_readback #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dbg         (dbg),
        .loader_busy (loader_busy),
        .latch_q     (latch_q),
        .rb_busy     (rb_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a capture completes after two consecutive loader-idle edges.
    logic [63:0] m_hold    = '0;
    logic        m_valid   = 1'b0;
    logic        m_busy    = 1'b0;
    logic        m_err     = 1'b0;
    logic        m_ovr     = 1'b0;
    logic        m_autoinc = 1'b0;
    int          m_index   = 0;
    int          m_run     = 0;

    function automatic logic [63:0] m_entry(input int i);
        return {32'(32'hA000_0000 + i), 32'(32'h5000_0000 + i)};
    endfunction

    function automatic logic [31:0] m_dout(input logic [5:0] a);
        case (a)
            6'h10:   return m_hold[31:0];
            6'h14:   return m_hold[63:32];
            6'h1C:   return (32'(m_index) << 8) | (32'(m_ovr) << 4) | (32'(m_err) << 3)
                          | (32'(m_autoinc) << 2) | (32'(m_busy) << 1) | 32'(m_valid);
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold = '0; m_valid = 0; m_busy = 0; m_err = 0;
            m_ovr = 0; m_autoinc = 0; m_index = 0; m_run = 0;
        end else begin
            if (m_busy) begin
                if (dbg.debug_wr && dbg.address == 6'h18) m_ovr = 1;
                if (loader_busy) m_run = 0;
                else m_run = m_run + 1;
                if (m_run == 2) begin
                    m_hold = m_entry(m_index);
                    m_valid = 1; m_busy = 0;
                end
            end else if (dbg.debug_wr && dbg.address == 6'h18) begin
                m_ovr = 0;
                if (int'(dbg.data_in[7:0]) >= int'(DEPTH)) begin
                    m_err = 1;
                end else begin
                    m_index = int'(dbg.data_in[7:0]);
                    m_autoinc = dbg.data_in[8];
                    m_err = 0; m_busy = 1; m_valid = 0; m_run = 0;
                end
            end else if (dbg.debug_rd && dbg.address == 6'h14 && m_autoinc && m_valid) begin
                m_index = (m_index + 1) % DEPTH;
                m_err = 0; m_busy = 1; m_valid = 0; m_run = 0;
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if (dbg.data_out !== m_dout(dbg.address)) begin
            errors++;
            $display("FAIL model_data_out addr=%h got %h want %h", dbg.address, dbg.data_out, m_dout(dbg.address));
        end
        checks++;
        if (rb_busy !== m_busy) begin
            errors++;
            $display("FAIL model_rb_busy got %b want %b", rb_busy, m_busy);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rd(input string name, input logic [5:0] a, input logic [31:0] want);
        dbg.address = a;
        #1;
        checks++;
        if (dbg.data_out !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, dbg.data_out, want);
        end
    endtask

    // Issue a REQ write for one edge, leaving the bus idle afterwards.
    task automatic req(input logic [31:0] d);
        dbg.debug_wr = 1'b1;
        dbg.address  = 6'h18;
        dbg.data_in  = d;
        cyc();
        dbg.debug_wr = 1'b0;
        dbg.data_in  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++)
            latch_q[i*WIDTH +: WIDTH] = m_entry(i);
        rst_n = 1'b0;
        loader_busy = 1'b0;
        dbg.debug_wr = 1'b0;
        dbg.debug_rd = 1'b0;
        dbg.address = 6'h00;
        dbg.data_in = '0;
        cyc(); cyc();
        check_rd("reset_lsb", 6'h10, 32'h0);
        check_rd("reset_msb", 6'h14, 32'h0);
        check_rd("reset_stat", 6'h1C, 32'h0);
        rst_n = 1'b1;
        cyc();

        // Basic capture of entry 3
        req(32'h3);
        cyc();
        check_rd("busy_stat", 6'h1C, 32'h0302);
        cyc();
        check_rd("e3_lsb", 6'h10, 32'h5000_0003);
        check_rd("e3_msb", 6'h14, 32'hA000_0003);
        check_rd("e3_stat", 6'h1C, 32'h0301);

        // Auto-increment wraps index 7 to 0
        req(32'h107);
        cyc(); cyc();
        check_rd("e7_stat", 6'h1C, 32'h0705);
        dbg.debug_rd = 1'b1;
        check_rd("inc_msb", 6'h14, 32'hA000_0007);
        cyc();
        dbg.debug_rd = 1'b0;
        check_rd("wrap_stat", 6'h1C, 32'h0006);
        cyc(); cyc();
        check_rd("wrap_lsb", 6'h10, 32'h5000_0000);
        check_rd("wrap_done", 6'h1C, 32'h0005);

        // Loader busy stall in ARM
        loader_busy = 1'b1;
        req(32'h2);
        repeat (5) cyc();
        check_rd("stall_stat", 6'h1C, 32'h0202);
        loader_busy = 1'b0;
        cyc();
        check_rd("stall_1", 6'h1C, 32'h0202);
        cyc();
        check_rd("stall_done", 6'h1C, 32'h0201);
        check_rd("e2_lsb", 6'h10, 32'h5000_0002);

        // Loader busy pulse during SETTLE
        req(32'h6);
        cyc();
        loader_busy = 1'b1;
        cyc();
        loader_busy = 1'b0;
        check_rd("settle_hold", 6'h10, 32'h5000_0002);
        check_rd("settle_stat", 6'h1C, 32'h0602);
        cyc(); cyc();
        check_rd("e6_lsb", 6'h10, 32'h5000_0006);
        check_rd("e6_msb", 6'h14, 32'hA000_0006);

        // Out-of-range index
        req(32'h9);
        check_rd("oob_stat", 6'h1C, 32'h0609);
        cyc(); cyc();
        check_rd("oob_hold", 6'h10, 32'h5000_0006);
        check_rd("oob_stat2", 6'h1C, 32'h0609);
        req(32'h1);
        cyc(); cyc();
        check_rd("err_clr", 6'h1C, 32'h0101);
        check_rd("e1_lsb", 6'h10, 32'h5000_0001);

        // Overrun: second REQ while capturing is ignored
        req(32'h4);
        req(32'h5);
        cyc();
        check_rd("ovr_stat", 6'h1C, 32'h0411);
        check_rd("ovr_lsb", 6'h10, 32'h5000_0004);

        // Read and REQ together: the REQ is taken, no increment
        req(32'h103);
        cyc(); cyc();
        check_rd("ai3_stat", 6'h1C, 32'h0305);
        dbg.debug_rd = 1'b1;
        req(32'h105);
        dbg.debug_rd = 1'b0;
        cyc(); cyc();
        check_rd("both_stat", 6'h1C, 32'h0505);
        check_rd("both_lsb", 6'h10, 32'h5000_0005);

        // Reset mid-capture
        req(32'h2);
        cyc();
        rst_n = 1'b0;
        check_rd("rst_lsb", 6'h10, 32'h0);
        check_rd("rst_msb", 6'h14, 32'h0);
        check_rd("rst_stat", 6'h1C, 32'h0);
        checks++;
        if (rb_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy got %b want 0", rb_busy);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        req(32'h7);
        cyc(); cyc();
        check_rd("post_rst_lsb", 6'h10, 32'h5000_0007);
        check_rd("post_rst_stat", 6'h1C, 32'h0701);

        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
